// File: rtl/seg_pkg.sv
// Shared types and 7-segment glyph table for the seg_key_display block.
package seg_pkg;

    typedef enum logic {
        ST_DISPLAY = 1'b0,
        ST_EDIT    = 1'b1
    } state_t;

    // Segment order is {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter, and a
// one-cycle press pulse on the accepted rising level.
module key_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_i,
    output logic level_o,
    output logic press_o
);

    logic        sync1;
    logic        sync2;
    logic        valid1;
    logic        valid2;
    logic        armed;
    logic        level_prev;
    logic [15:0] cnt;

    // The valid chain marks when sync2 holds a real post-reset sample; a press
    // is only armed once the key has been seen released, so a key held through
    // reset never produces a pulse until it is released and pressed again.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            valid1     <= 1'b0;
            valid2     <= 1'b0;
            armed      <= 1'b0;
            level_o    <= 1'b0;
            level_prev <= 1'b0;
            press_o    <= 1'b0;
            cnt        <= 16'd0;
        end else begin
            sync1      <= key_i;
            sync2      <= sync1;
            valid1     <= 1'b1;
            valid2     <= valid1;
            if (valid2 && !sync2) begin
                armed <= 1'b1;
            end
            if (sync2 != level_o) begin
                if (cnt == DEBOUNCE_CYCLES) begin
                    level_o <= sync2;
                    cnt     <= 16'd0;
                end else begin
                    cnt <= cnt + 16'd1;
                end
            end else begin
                cnt <= 16'd0;
            end
            level_prev <= level_o;
            press_o    <= level_o & ~level_prev & armed;
        end
    end

endmodule

// File: rtl/seg_key_display.sv
// N-digit BCD counter with mode/add buttons and a multiplexed 7-segment driver.
// Define SEG_BLINK_EN to blink the digit under edit.
module seg_key_display
    import seg_pkg::*;
#(
    parameter int          DIGITS          = 4,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [15:0] SCAN_DIV        = 16'd1000
`ifdef SEG_BLINK_EN
    ,
    parameter int          BLINK_BIT       = 22
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_mode_i,
    input  logic                  key_add_i,
    output logic [6:0]            seg_o,
    output logic [DIGITS-1:0]     dig_o,
    output logic [4*DIGITS-1:0]   value_o,
    output logic                  edit_o,
    output logic [2:0]            sel_o,
    output logic                  ovf_o
);

    localparam logic [2:0] SEL_MAX = 3'(DIGITS - 1);

    logic                mode_press;
    logic                add_press;
    logic                mode_level;
    logic                add_level;
    logic                unused_levels;
    state_t              state;
    logic [4*DIGITS-1:0] value_inc;
    logic [4*DIGITS-1:0] value_edit;
    logic                carry;
    logic [15:0]         presc;
    logic [2:0]          scan_idx;
    logic [2:0]          next_idx;
    logic [DIGITS-1:0]   dig_next;
    logic [3:0]          scan_nibble;
    logic [6:0]          seg_next;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_key (
        .clk     (clk),
        .rst     (rst),
        .key_i   (key_mode_i),
        .level_o (mode_level),
        .press_o (mode_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_add_key (
        .clk     (clk),
        .rst     (rst),
        .key_i   (key_add_i),
        .level_o (add_level),
        .press_o (add_press)
    );

    assign unused_levels = mode_level ^ add_level;

    // Whole-number decimal increment with ripple carry; carry out means wrap.
    always_comb begin
        value_inc = value_o;
        carry     = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (value_o[4*i +: 4] == 4'd9) begin
                    value_inc[4*i +: 4] = 4'd0;
                end else begin
                    value_inc[4*i +: 4] = value_o[4*i +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
    end

    always_comb begin
        value_edit = value_o;
        for (int i = 0; i < DIGITS; i++) begin
            if (sel_o == 3'(i)) begin
                value_edit[4*i +: 4] = (value_o[4*i +: 4] == 4'd9) ? 4'd0 : value_o[4*i +: 4] + 4'd1;
            end
        end
    end

    // Mode wins over a coincident add pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_DISPLAY;
            edit_o  <= 1'b0;
            sel_o   <= 3'd0;
            value_o <= '0;
            ovf_o   <= 1'b0;
        end else begin
            ovf_o <= 1'b0;
            if (mode_press) begin
                if (state == ST_DISPLAY) begin
                    state  <= ST_EDIT;
                    edit_o <= 1'b1;
                    sel_o  <= 3'd0;
                end else if (sel_o == SEL_MAX) begin
                    state  <= ST_DISPLAY;
                    edit_o <= 1'b0;
                    sel_o  <= 3'd0;
                end else begin
                    sel_o <= sel_o + 3'd1;
                end
            end else if (add_press) begin
                if (state == ST_DISPLAY) begin
                    value_o <= value_inc;
                    ovf_o   <= carry;
                end else begin
                    value_o <= value_edit;
                end
            end
        end
    end

`ifdef SEG_BLINK_EN
    logic [BLINK_BIT:0] blink_cnt;

    always_ff @(posedge clk) begin
        if (rst || mode_press) begin
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + (BLINK_BIT + 1)'(1);
        end
    end
`endif

    always_comb begin
        next_idx = scan_idx;
        if (presc == SCAN_DIV - 16'd1) begin
            next_idx = (scan_idx == SEL_MAX) ? 3'd0 : scan_idx + 3'd1;
        end
        dig_next    = '0;
        scan_nibble = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (next_idx == 3'(i)) begin
                dig_next[i] = 1'b1;
                scan_nibble = value_o[4*i +: 4];
            end
        end
        seg_next = bcd_to_seg(scan_nibble);
`ifdef SEG_BLINK_EN
        if (state == ST_EDIT && next_idx == sel_o && blink_cnt[BLINK_BIT]) begin
            seg_next = SEG_BLANK;
        end
`endif
    end

    // Digit enable and segments are registered together so they switch on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc    <= 16'd0;
            scan_idx <= 3'd0;
            dig_o    <= DIGITS'(1);
            seg_o    <= SEG_0;
        end else begin
            presc    <= (presc == SCAN_DIV - 16'd1) ? 16'd0 : presc + 16'd1;
            scan_idx <= next_idx;
            dig_o    <= dig_next;
            seg_o    <= seg_next;
        end
    end

endmodule

// File: tb/tb_seg_key_display.sv
// Self-checking bench for seg_key_display: table of key presses, decimal model,
// scan pattern checks and reset-during-debounce sequence.
`timescale 1ns/1ps
module tb_seg_key_display;

    localparam int DIGITS = 4;
    localparam int DEB    = 4;
    localparam int SDIV   = 3;

    typedef struct {
        logic        mode;
        logic        add;
        logic [15:0] value;
        logic        edit;
        logic [2:0]  sel;
        logic        ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_mode_i;
    logic        key_add_i;
    logic [6:0]  seg_o;
    logic [3:0]  dig_o;
    logic [15:0] value_o;
    logic        edit_o;
    logic [2:0]  sel_o;
    logic        ovf_o;

    vec_t        exp_q[$];
    vec_t        last;
    vec_t        tbl[14];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          md[4];
    bit          medit;
    int          msel;
    logic [6:0]  glyph[10];

    always #5 clk = ~clk;

    seg_key_display #(
        .DIGITS          (DIGITS),
        .DEBOUNCE_CYCLES (16'(DEB)),
        .SCAN_DIV        (16'(SDIV))
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_mode_i (key_mode_i),
        .key_add_i  (key_add_i),
        .seg_o      (seg_o),
        .dig_o      (dig_o),
        .value_o    (value_o),
        .edit_o     (edit_o),
        .sel_o      (sel_o),
        .ovf_o      (ovf_o)
    );

    // Cycles since the last reset edge; drives the expected scan position.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_value();
        return {4'(md[3]), 4'(md[2]), 4'(md[1]), 4'(md[0])};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) md[i] = 0;
        medit      = 1'b0;
        msel       = 0;
        last.mode  = 1'b0;
        last.add   = 1'b0;
        last.value = 16'h0000;
        last.edit  = 1'b0;
        last.sel   = 3'd0;
        last.ovf   = 1'b0;
    endtask

    task automatic check_output();
        vec_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = exp_q.pop_front();
            check("value", {16'h0, value_o}, {16'h0, e.value});
            check("edit", {31'h0, edit_o}, {31'h0, e.edit});
            check("sel", {29'h0, sel_o}, {29'h0, e.sel});
            check("ovf", {31'h0, ovf_o}, {31'h0, e.ovf});
            last = e;
        end
    endtask

    // Press is first sampled at edge 0; outputs must be unchanged at edge DEB+3
    // and updated at edge DEB+4, with ovf gone again one edge later.
    task automatic apply_stimulus(input vec_t e);
        exp_q.push_back(e);
        @(negedge clk);
        key_mode_i = e.mode;
        key_add_i  = e.add;
        repeat (DEB + 4) @(posedge clk);
        #1;
        check("pre_pulse", {11'h0, value_o, edit_o, sel_o, ovf_o},
              {11'h0, last.value, last.edit, last.sel, 1'b0});
        @(posedge clk);
        #1;
        check_output();
        @(posedge clk);
        #1;
        check("ovf_width", {31'h0, ovf_o}, 32'h0);
        @(negedge clk);
        key_mode_i = 1'b0;
        key_add_i  = 1'b0;
        repeat (DEB + 6) @(negedge clk);
    endtask

    task automatic press_model(input logic m, input logic a);
        vec_t e;
        int   n;
        e.mode = m;
        e.add  = a;
        e.ovf  = 1'b0;
        if (m) begin
            if (!medit) begin
                medit = 1'b1;
                msel  = 0;
            end else if (msel == DIGITS - 1) begin
                medit = 1'b0;
                msel  = 0;
            end else begin
                msel++;
            end
        end else if (a) begin
            if (medit) begin
                md[msel] = (md[msel] + 1) % 10;
            end else begin
                n = md[0] + 10 * md[1] + 100 * md[2] + 1000 * md[3];
                n = (n + 1) % 10000;
                e.ovf = (n == 0);
                for (int i = 0; i < 4; i++) begin
                    md[i] = n % 10;
                    n     = n / 10;
                end
            end
        end
        e.value = model_value();
        e.edit  = medit;
        e.sel   = 3'(msel);
        apply_stimulus(e);
    endtask

    task automatic scan_check(input int n);
        int idx;
        repeat (n) begin
            @(posedge clk);
            #1;
            idx = (cyc / SDIV) % DIGITS;
            check("scan_dig", {28'h0, dig_o}, 32'h1 << idx);
            check("scan_seg", {25'h0, seg_o}, {25'h0, glyph[md[idx]]});
        end
    endtask

    initial begin
        glyph[0] = 7'h3F; glyph[1] = 7'h06; glyph[2] = 7'h5B; glyph[3] = 7'h4F;
        glyph[4] = 7'h66; glyph[5] = 7'h6D; glyph[6] = 7'h7D; glyph[7] = 7'h07;
        glyph[8] = 7'h7F; glyph[9] = 7'h6F;

        tbl[0]  = '{1'b0, 1'b1, 16'h0001, 1'b0, 3'd0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 16'h0001, 1'b1, 3'd0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 16'h0001, 1'b1, 3'd1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 16'h0011, 1'b1, 3'd1, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 16'h0021, 1'b1, 3'd1, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 16'h0021, 1'b1, 3'd2, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 16'h0021, 1'b1, 3'd3, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 16'h0021, 1'b0, 3'd0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 16'h0022, 1'b0, 3'd0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 16'h0022, 1'b1, 3'd0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 16'h0022, 1'b1, 3'd1, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 16'h0022, 1'b1, 3'd2, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 16'h0022, 1'b1, 3'd3, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 16'h0022, 1'b0, 3'd0, 1'b0};

        model_clear();
        rst        = 1'b1;
        key_mode_i = 1'b0;
        key_add_i  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_value", {16'h0, value_o}, 32'h0);
        check("rst_edit_sel_ovf", {27'h0, edit_o, sel_o, ovf_o}, 32'h0);
        check("rst_dig", {28'h0, dig_o}, 32'h1);
        check("rst_seg", {25'h0, seg_o}, 32'h3F);

        scan_check(20);

        // Press too short to survive debouncing.
        @(negedge clk);
        key_add_i = 1'b1;
        repeat (3) @(negedge clk);
        key_add_i = 1'b0;
        repeat (14) @(negedge clk);
        check("glitch_value", {15'h0, value_o, ovf_o}, 32'h0);

        for (int i = 0; i < 14; i++) begin
            apply_stimulus(tbl[i]);
        end

        for (int i = 0; i < 4; i++) md[i] = int'(last.value[4*i +: 4]);
        medit = last.edit;
        msel  = int'(last.sel);
        scan_check(12);

        // Ripple carry 0022 -> 0030, then preload 9999 digit by digit in EDIT,
        // including a 9 -> 0 wrap on digit 0 that must not carry.
        repeat (8) press_model(1'b0, 1'b1);
        press_model(1'b1, 1'b0);
        repeat (10) press_model(1'b0, 1'b1);
        repeat (9) press_model(1'b0, 1'b1);
        press_model(1'b1, 1'b0);
        repeat (6) press_model(1'b0, 1'b1);
        press_model(1'b1, 1'b0);
        repeat (9) press_model(1'b0, 1'b1);
        press_model(1'b1, 1'b0);
        repeat (9) press_model(1'b0, 1'b1);
        press_model(1'b1, 1'b0);
        check("preload_9999", {16'h0, value_o}, 32'h9999);
        press_model(1'b0, 1'b1);
        scan_check(12);

        // Reset in the middle of a debounce while editing.
        press_model(1'b0, 1'b1);
        press_model(1'b1, 1'b0);
        @(negedge clk);
        key_add_i = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        check("midrst_value", {16'h0, value_o}, 32'h0);
        check("midrst_edit_sel", {28'h0, edit_o, sel_o}, 32'h0);
        check("midrst_dig", {28'h0, dig_o}, 32'h1);
        check("midrst_seg", {25'h0, seg_o}, 32'h3F);
        repeat (20) @(negedge clk);
        check("held_after_rst", {15'h0, value_o, edit_o}, 32'h0);
        key_add_i = 1'b0;
        repeat (12) @(negedge clk);
        press_model(1'b0, 1'b1);
        check("queue_drain", exp_q.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
